// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR controller driving one external combinational
// multiply-accumulate unit. Owns the sample delay line, the coefficient file
// and the accumulator; runs TAPS MAC cycles per accepted input sample.
// Build option: define FIR_SAT_EN to saturate the scaled result to the signed
// OUTBITS range; otherwise the scaled result wraps (low OUTBITS bits kept).
`timescale 1ns/1ps

module fir_mac_sequencer #(
    parameter int TAPS     = 5,
    parameter int SHIFT    = 15,
    parameter int DATABITS = 16,
    parameter int OUTBITS  = DATABITS,
    parameter int ACCBITS  = 16 + DATABITS + $clog2(TAPS),
    localparam int AW      = $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATABITS-1:0] in_data,
    input  logic                       coef_we,
    input  logic        [AW-1:0]       coef_addr,
    input  logic signed [15:0]         coef_data,
    output logic signed [15:0]         mac_c,
    output logic signed [DATABITS-1:0] mac_d,
    output logic signed [ACCBITS-1:0]  mac_acc,
    input  logic signed [ACCBITS-1:0]  mac_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUTBITS-1:0]  out_data,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    state_t                       state;
    logic        [AW-1:0]         k;
    logic        [AW-1:0]         newest;
    logic        [AW-1:0]         wr_ptr;
    logic signed [ACCBITS-1:0]    acc;
    logic signed [DATABITS-1:0]   delay [TAPS];
    logic signed [15:0]           coef  [TAPS];

    logic                         in_fire;
    logic                         coef_wr_ok;
    logic        [AW-1:0]         rd_idx;
    logic        [AW-1:0]         wr_ptr_next;
    logic signed [OUTBITS-1:0]    out_next;

    // in_ready is a registered copy of (state == IDLE), so this is the handshake.
    assign in_fire     = in_valid && in_ready;
    assign wr_ptr_next = (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;

    // Coefficient writes land only while idle (including the handshake cycle)
    // and only for in-range addresses.
    assign coef_wr_ok  = coef_we && (state == IDLE)
                         && ({1'b0, coef_addr} < (AW+1)'(TAPS));

    // Tap read index (newest - k) mod TAPS, plus the MAC operand drive.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; a missing default would infer a latch.
        rd_idx  = newest - k + ((newest < k) ? AW'(TAPS) : '0);
        mac_c   = '0;
        mac_d   = '0;
        mac_acc = '0;
        if (state == RUN) begin
            mac_c   = coef[k];
            mac_d   = delay[rd_idx];
            mac_acc = acc;
        end
    end

    // Scale the final accumulator: arithmetic shift, then saturate or wrap.
`ifdef FIR_SAT_EN
    localparam logic signed [ACCBITS-1:0] OUT_MAX =
        ACCBITS'($signed({1'b0, {(OUTBITS-1){1'b1}}}));
    localparam logic signed [ACCBITS-1:0] OUT_MIN =
        ACCBITS'($signed({1'b1, {(OUTBITS-1){1'b0}}}));
    logic signed [ACCBITS-1:0] shifted;

    always_comb begin
        shifted = mac_sum >>> SHIFT;
        if (shifted > OUT_MAX) begin
            out_next = OUT_MAX[OUTBITS-1:0];
        end else if (shifted < OUT_MIN) begin
            out_next = OUT_MIN[OUTBITS-1:0];
        end else begin
            out_next = shifted[OUTBITS-1:0];
        end
    end
`else
    always_comb begin
        out_next = OUTBITS'(mac_sum >>> SHIFT);
    end
`endif

    // Sample delay line: the accepted sample overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this memory is deliberately reset; a reset must flush stale
        // history so the next output starts from an all-zero window.
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                delay[i] <= '0;
            end
        end else if (in_fire) begin
            delay[wr_ptr] <= in_data;
        end
    end

    // Coefficient register file, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr_ok) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Control FSM with registered handshake/status outputs and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            newest    <= '0;
            wr_ptr    <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        newest   <= wr_ptr;
                        wr_ptr   <= wr_ptr_next;
                        acc      <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= mac_sum;
                    if (k == LAST_TAP) begin
                        out_data  <= out_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer (TAPS=5, SHIFT=0, 16-bit data/output).
// Provides the combinational muladd, a sample-history reference model and
// table-driven plus randomized transactions.
`timescale 1ns/1ps

module tb_fir_mac_sequencer;

    localparam int TAPS     = 5;
    localparam int SHIFT    = 0;
    localparam int DATABITS = 16;
    localparam int OUTBITS  = 16;
    localparam int ACCBITS  = 16 + DATABITS + $clog2(TAPS);
    localparam int AW       = $clog2(TAPS);

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic signed [DATABITS-1:0] in_data = '0;
    logic                       coef_we = 1'b0;
    logic        [AW-1:0]       coef_addr = '0;
    logic signed [15:0]         coef_data = '0;
    logic signed [15:0]         mac_c;
    logic signed [DATABITS-1:0] mac_d;
    logic signed [ACCBITS-1:0]  mac_acc;
    logic signed [ACCBITS-1:0]  mac_sum;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic signed [OUTBITS-1:0]  out_data;
    logic                       busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: every sample accepted since reset, and coefficients.
    longint hist [$];
    longint coef_m [TAPS];

    typedef struct {
        logic [15:0] sample;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [11];

    fir_mac_sequencer #(
        .TAPS(TAPS), .SHIFT(SHIFT), .DATABITS(DATABITS),
        .OUTBITS(OUTBITS), .ACCBITS(ACCBITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .mac_c(mac_c), .mac_d(mac_d), .mac_acc(mac_acc), .mac_sum(mac_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    // Combinational muladd unit.
    assign mac_sum = mac_acc + mac_c * mac_d;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // y[n] = (sum_i coef[i] * x[n-i]) >>> SHIFT, then saturated or wrapped.
    function automatic logic [15:0] model_out();
        longint     a = 0;
        logic [63:0] ab;
        int         n = hist.size();
        for (int i = 0; i < TAPS; i++) begin
            if (i < n) a += coef_m[i] * hist[n-1-i];
        end
        a = a >>> SHIFT;
`ifdef FIR_SAT_EN
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
`endif
        ab = a;
        return ab[15:0];
    endfunction

    task automatic clear_model();
        hist.delete();
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [AW-1:0] addr, input logic [15:0] data);
        coef_we = 1'b1; coef_addr = addr; coef_data = data;
        tick();
        coef_we = 1'b0;
        if (int'(addr) < TAPS) coef_m[addr] = longint'($signed(data));
    endtask

    // One full transaction: handshake, RUN, hold DONE for `hold` cycles, then accept.
    task automatic send_sample(input logic [15:0] d, input bit cw_en,
                               input logic [AW-1:0] cw_addr, input logic [15:0] cw_data,
                               input bit busy_wr, input int hold, output logic [15:0] got);
        int          lat;
        int          waits = 0;
        logic [15:0] exp;
        logic [15:0] c0;
        while (!in_ready && waits < 50) begin
            tick();
            waits++;
        end
        check("in_ready_before_send", in_ready, 16'd1);
        in_valid = 1'b1; in_data = d;
        coef_we = cw_en; coef_addr = cw_addr; coef_data = cw_data;
        if (cw_en && int'(cw_addr) < TAPS) coef_m[cw_addr] = longint'($signed(cw_data));
        hist.push_back(longint'($signed(d)));
        if (hist.size() > TAPS) void'(hist.pop_front());
        exp = model_out();
        c0  = coef_m[0][15:0];
        tick();
        lat = 1;
        in_valid = 1'b0; coef_we = 1'b0; in_data = '0;
        check("run_mac_c_tap0", mac_c, c0);
        check("run_mac_d_tap0", mac_d, d);
        check("run_in_ready", in_ready, 16'd0);
        check("run_busy", busy, 16'd1);
        if (busy_wr) begin
            coef_we = 1'b1; coef_addr = '0; coef_data = 16'd9;
        end
        while (!out_valid && lat < 20) begin
            tick();
            coef_we = 1'b0;
            lat++;
        end
        check("latency", lat[15:0], 16'(TAPS + 1));
        check("out_data", out_data, exp);
        got = out_data;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_out_data", out_data, got);
            check("hold_out_valid", out_valid, 16'd1);
            check("hold_in_ready", in_ready, 16'd0);
            check("hold_busy", busy, 16'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 16'd0);
        check("post_hs_in_ready", in_ready, 16'd1);
        check("post_hs_busy", busy, 16'd0);
    endtask

    initial begin
        logic [15:0] got;
        int          viol;

        vecs[0]  = '{16'd1, 16'd1};
        vecs[1]  = '{16'd0, 16'd2};
        vecs[2]  = '{16'd0, 16'd3};
        vecs[3]  = '{16'd0, 16'd4};
        vecs[4]  = '{16'd0, 16'd5};
        vecs[5]  = '{16'd0, 16'd0};
        vecs[6]  = '{16'd1, 16'd1};
        vecs[7]  = '{16'd1, 16'd3};
        vecs[8]  = '{16'd1, 16'd6};
        vecs[9]  = '{16'd1, 16'd10};
        vecs[10] = '{16'd1, 16'd15};

        clear_model();
        #12;
        check("rst_in_ready", in_ready, 16'd1);
        check("rst_out_valid", out_valid, 16'd0);
        check("rst_out_data", out_data, 16'd0);
        check("rst_busy", busy, 16'd0);
        check("rst_mac_c", mac_c, 16'd0);
        check("rst_mac_d", mac_d, 16'd0);
        check("rst_mac_acc", mac_acc[15:0], 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Impulse then step with coefficients 1..5; out-of-range write ignored.
        for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 16'(i + 1));
        write_coef(AW'(TAPS), 16'd77);
        for (int i = 0; i < 11; i++) begin
            send_sample(vecs[i].sample, 1'b0, '0, '0, 1'b0, 0, got);
            check("table_out", got, vecs[i].exp);
        end

        // Backpressure: DONE held for 10 cycles.
        send_sample(16'd2, 1'b0, '0, '0, 1'b0, 10, got);

        // Coefficient write during RUN must not take effect.
        send_sample(16'd1, 1'b0, '0, '0, 1'b1, 0, got);
        send_sample(16'd0, 1'b0, '0, '0, 1'b0, 0, got);

        // Coefficient write in the same cycle as the handshake takes effect.
        send_sample(16'd3, 1'b1, AW'(0), 16'd4, 1'b0, 0, got);

        // Saturation / wrap.
        for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 16'h7FFF);
        for (int i = 0; i < TAPS; i++) send_sample(16'h7FFF, 1'b0, '0, '0, 1'b0, 0, got);
`ifdef FIR_SAT_EN
        check("sat_final", got, 16'h7FFF);
`else
        check("wrap_final", got, 16'h0005);
`endif

        // Randomized transactions against the model.
        for (int t = 0; t < 25; t++) begin
            int nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++)
                write_coef(AW'($urandom_range(0, (1 << AW) - 1)), 16'($urandom));
            send_sample(16'($urandom), 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, (1 << AW) - 1)), 16'($urandom),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3), got);
        end

        // Reset asserted mid-RUN at k = 2.
        in_valid = 1'b1; in_data = 16'd5;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        clear_model();
        check("midrst_in_ready", in_ready, 16'd1);
        check("midrst_out_valid", out_valid, 16'd0);
        check("midrst_busy", busy, 16'd0);
        check("midrst_mac_c", mac_c, 16'd0);
        tick();
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid || !in_ready) viol++;
        end
        check("midrst_no_output", viol[15:0], 16'd0);
        send_sample(16'd1, 1'b0, '0, '0, 1'b0, 0, got);
        check("midrst_zero_coef_impulse", got, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR controller that drives a single combinational multiply-accumulate unit (`muladd`) over `TAPS` coefficient/sample pairs per input sample. It owns the sample delay line, the coefficient register file and the accumulator register. It accepts one sample per valid/ready handshake, runs `TAPS` MAC cycles, and presents the scaled result on a valid/ready output. It sits between the sample source and the filter output stage in the FIR filter top.

## Interface

Parameters:
- `TAPS`, 5, number of filter taps (≥2).
- `SHIFT`, 15, right-shift applied to the accumulator before output (Q15 coefficients).
- `OUTBITS`, `DATABITS`, output sample width.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  sequencer can accept a sample.
- `in_data`  in  DATABITS  signed input sample.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(TAPS)  coefficient index; 0 is the newest-sample tap.
- `coef_data`  in  16  signed coefficient.
- `mac_c`  out  16  coefficient to `muladd.c_in`.
- `mac_d`  out  DATABITS  sample to `muladd.d_in`.
- `mac_acc`  out  ACCBITS  accumulator to `muladd.acc_in`.
- `mac_sum`  in  ACCBITS  `muladd.sum_out`; combinational in the same cycle.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  OUTBITS  signed filter output.
- `busy`  out  1  high in RUN or DONE.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: write `in_data` to `delay[wr_ptr]`, latch `newest`=`wr_ptr`, set `wr_ptr` to (`wr_ptr`+1) mod `TAPS`, clear `acc`, set tap counter `k`=0, go to RUN.
- RUN, one tap per cycle:
  - `mac_c`=`coef[k]`.
  - `mac_d`=`delay[(newest−k) mod TAPS]`.
  - `mac_acc`=`acc`.
  - `acc`<=`mac_sum`.
  - At `k`=`TAPS`−1, register `out_data` from `mac_sum` and go to DONE. Otherwise increment `k`.
- DONE: `out_valid`=1 and `out_data` is held stable. On `out_ready`, go to IDLE.
- Outside RUN, `mac_c`, `mac_d` and `mac_acc` are driven 0.
- Output scaling: `out_data` = `acc_final` arithmetically shifted right by `SHIFT`, then reduced to `OUTBITS` as described in Configuration.
- Coefficient writes:
  - Accepted only in IDLE, and also in the same cycle as an input handshake.
  - `coef_we` in RUN or DONE is ignored.
  - `coef_addr` ≥ `TAPS` is ignored.
- `in_ready` is 0 in RUN and DONE. There is no input buffering; the source must hold its sample.
- Sample index wrap: `(newest−k)` wraps modulo `TAPS`. `wr_ptr` wraps from `TAPS`−1 to 0.

## Timing

- Reset values:
  - State IDLE.
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0, `mac_*`=0.
  - `acc`=0, `k`=0, `wr_ptr`=0.
  - All `delay[]`=0 and all `coef[]`=0.
- Latency: input handshake in cycle 0; RUN occupies cycles 1..`TAPS`; `out_valid` rises in cycle `TAPS`+1.
- Throughput: with `out_ready` held high, one sample per `TAPS`+2 cycles. DONE→IDLE takes one cycle, and `in_ready` returns the cycle after the output handshake.
- Backpressure: DONE is held indefinitely while `out_ready`=0.
- Reset asserted at any time, including mid-RUN:
  - The FSM returns immediately to IDLE.
  - The partial result is discarded and no `out_valid` is produced.
  - The delay line and coefficients are cleared.
- `out_ready` asserted outside DONE has no effect.

## Configuration

- `FIR_SAT_EN` defined: the shifted accumulator saturates to the signed `OUTBITS` range, i.e. −2^(OUTBITS−1) to 2^(OUTBITS−1)−1.
- `FIR_SAT_EN` undefined: the shifted accumulator is truncated to its low `OUTBITS` bits (two's-complement wrap).

## Test plan

- Impulse response (`TAPS`=5, `SHIFT`=0): coefficients 1,2,3,4,5, then feed 1,0,0,0,0,0 -> `out_data` = 1,2,3,4,5,0. Each `out_valid` appears 6 cycles after its handshake.
- Step, `out_ready` held high (`SHIFT`=0): coefficients 1,2,3,4,5, feed five 1s -> outputs 1,3,6,10,15. `in_ready` returns 1 cycle after each output handshake.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `out_data` stable, `in_ready`=0, `busy`=1 throughout; output handshake on the first cycle `out_ready`=1.
- Saturation (`SHIFT`=0, `OUTBITS`=16): all coefficients 0x7FFF, five samples of 0x7FFF:
  - With `FIR_SAT_EN` -> final output 0x7FFF.
  - Without it -> low 16 bits of 5·0x7FFF·0x7FFF.
- Coefficient write while busy: `coef_we` to index 0 with value 9 during RUN -> ignored; the next impulse output still uses the old `coef[0]`.
- Reset mid-RUN: assert `rst_n`=0 at `k`=2 -> no `out_valid`, `in_ready`=1 after release, and an impulse with zero coefficients then outputs 0.
